// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - opcode enum and shared constants for the logic unit
package logic_unit_pkg;

    localparam int LOGIC_OP_W = 3;

    typedef enum logic [LOGIC_OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NOR   = 3'd2,
        OP_NAND  = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOT_A = 3'd6,
        OP_PASS_A = 3'd7
    } logic_op_e;

endpackage

// File: rtl/logic_unit_if.sv
// rtl/logic_unit_if.sv - command/result bus of the logic unit (LOGIC_UNIT_REDUCE_EN adds reduction flags)
interface logic_unit_if
    import logic_unit_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic_op_e        op;
    logic             acc_en;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     y;
    logic [W-1:0]     acc;
    logic [CNT_W-1:0] count;
`ifdef LOGIC_UNIT_REDUCE_EN
    logic             y_zero;
    logic             y_ones;
    logic             y_par;

    modport master (
        output in_valid, a, b, op, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, y, acc, count, y_zero, y_ones, y_par
    );

    modport slave (
        input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, y, acc, count, y_zero, y_ones, y_par
    );
`else
    modport master (
        output in_valid, a, b, op, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, y, acc, count
    );

    modport slave (
        input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, y, acc, count
    );
`endif
endinterface

// File: rtl/logic_unit_core.sv
// rtl/logic_unit_core.sv - combinational W-bit bitwise function of two operands
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic_op_e    i_op,
    output logic [W-1:0] o_y
);

    // select the bitwise function; NOT_A and PASS_A ignore i_b
    always_comb begin
        o_y = '0;
        case (i_op)
            OP_AND:    o_y = i_a & i_b;
            OP_OR:     o_y = i_a | i_b;
            OP_NOR:    o_y = ~(i_a | i_b);
            OP_NAND:   o_y = ~(i_a & i_b);
            OP_XOR:    o_y = i_a ^ i_b;
            OP_XNOR:   o_y = ~(i_a ^ i_b);
            OP_NOT_A:  o_y = ~i_a;
            OP_PASS_A: o_y = i_a;
            default:   o_y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit.sv
// rtl/logic_unit.sv - registered logic unit with accumulator and counter (LOGIC_UNIT_REDUCE_EN adds y_zero/y_ones/y_par)
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int             W        = 8,
    parameter int             CNT_W    = 16,
    parameter logic [W-1:0]   ACC_INIT = '0
) (
    input  logic           clk,
    input  logic           reset,
    logic_unit_if.slave    bus
);

    logic             r_out_valid;
    logic [W-1:0]     r_y;
    logic [W-1:0]     r_acc;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic [W-1:0]     w_eff_a;
    logic [W-1:0]     w_result;

    assign bus.in_ready = !r_out_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // a clear in the same cycle as an accumulate folds from ACC_INIT, not the old value
    assign w_eff_a = bus.acc_en ? (bus.acc_clr ? ACC_INIT : r_acc) : bus.a;

    logic_unit_core #(.W(W)) u_core (
        .i_a  (w_eff_a),
        .i_b  (bus.b),
        .i_op (bus.op),
        .o_y  (w_result)
    );

    // output stage: load on accept, drop valid on a delivery with nothing new behind it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_y         <= w_result;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // accumulator: fold the result on an accumulate accept, otherwise honour a clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= ACC_INIT;
        end else if (w_accept && bus.acc_en) begin
            r_acc <= w_result;
        end else if (bus.acc_clr) begin
            r_acc <= ACC_INIT;
        end
    end

    // accepted-transaction counter, sticking at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_accept && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.y         = r_y;
    assign bus.acc       = r_acc;
    assign bus.count     = r_count;

`ifdef LOGIC_UNIT_REDUCE_EN
    logic r_y_zero;
    logic r_y_ones;
    logic r_y_par;

    // reduction flags track y exactly: loaded on accept, held otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_y_zero <= 1'b0;
            r_y_ones <= 1'b0;
            r_y_par  <= 1'b0;
        end else if (w_accept) begin
            r_y_zero <= ~|w_result;
            r_y_ones <= &w_result;
            r_y_par  <= ^w_result;
        end
    end

    assign bus.y_zero = r_y_zero;
    assign bus.y_ones = r_y_ones;
    assign bus.y_par  = r_y_par;
`endif

endmodule
